coffee_order_controller: RTL and testbench

- Sequential controller for the coffee machine datapath: accumulates inserted coins, latches the drink selection and checks the credit against the drink price.
- Drives the brew timer for a fixed number of cycles, then issues change or a full refund.
- Sits between the coin/button front end and the display and dispenser outputs, and owns the price-compare/subtract function internally.

---
 rtl/coffee_order_controller.sv | 185 ++++++++++++++++++
 tb/tb_coffee_order_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_order_controller.sv
// Coffee machine order controller: collects coins, latches the drink choice,
// checks credit against price, times the brew and pays out change or a refund.
module coffee_order_controller #(
  parameter int unsigned PRICE_ESPRESSO   = 3,
  parameter int unsigned PRICE_MILK       = 4,
  parameter int unsigned PRICE_CAPPUCCINO = 5,
  parameter int unsigned PRICE_MOCACCINO  = 7,
  parameter int unsigned BREW_CYCLES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic       select_valid,
  input  logic [2:0] coffee_type,
  input  logic       cancel,
  output logic [3:0] total_coins,
  output logic       dispensing,
  output logic       change_valid,
  output logic [3:0] change,
  output logic       coin_reject,
  output logic       select_error,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_BREW    = 3'd3;
  localparam logic [2:0] S_PAYOUT  = 3'd4;

  localparam logic [3:0] P_ESPRESSO   = 4'(PRICE_ESPRESSO);
  localparam logic [3:0] P_MILK       = 4'(PRICE_MILK);
  localparam logic [3:0] P_CAPPUCCINO = 4'(PRICE_CAPPUCCINO);
  localparam logic [3:0] P_MOCACCINO  = 4'(PRICE_MOCACCINO);
  localparam logic [7:0] BREW_LOAD    = 8'(BREW_CYCLES);
  localparam logic [3:0] CREDIT_MAX   = 4'd15;

  logic [2:0] r_state;
  logic [3:0] r_total;
  logic [1:0] r_type;
  logic [3:0] r_change_reg;
  logic [7:0] r_timer;
  logic       r_dispensing;
  logic       r_change_valid;
  logic [3:0] r_change;
  logic       r_coin_reject;
  logic       r_select_error;

  logic [2:0] w_state;
  logic [3:0] w_total;
  logic [1:0] w_type;
  logic [3:0] w_change_reg;
  logic [7:0] w_timer;
  logic       w_dispensing;
  logic       w_change_valid;
  logic [3:0] w_change;
  logic       w_coin_reject;
  logic       w_select_error;
  logic [3:0] w_price;
  logic       w_type_legal;

  assign w_type_legal = ~coffee_type[2];

  always_comb begin
    case (r_type)
      2'd0: w_price = P_ESPRESSO;
      2'd1: w_price = P_MILK;
      2'd2: w_price = P_CAPPUCCINO;
      2'd3: w_price = P_MOCACCINO;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state        = r_state;
    w_total        = r_total;
    w_type         = r_type;
    w_change_reg   = r_change_reg;
    w_timer        = r_timer;
    w_dispensing   = 1'b0;
    w_change_valid = 1'b0;
    w_change       = r_change;
    w_coin_reject  = 1'b0;
    w_select_error = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A select consumes the cycle, so a coincident coin is turned away.
        if (select_valid) begin
          w_select_error = 1'b1;
          w_coin_reject  = coin_valid;
        end else if (coin_valid) begin
          w_total = 4'd1;
          w_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          w_change       = r_total;
          w_change_valid = 1'b1;
          w_total        = 4'd0;
          w_coin_reject  = coin_valid;
          w_state        = S_PAYOUT;
        end else if (select_valid) begin
          w_coin_reject = coin_valid;
          if (w_type_legal) begin
            w_type  = coffee_type[1:0];
            w_state = S_CHECK;
          end else begin
            w_select_error = 1'b1;
          end
        end else if (coin_valid) begin
          if (r_total == CREDIT_MAX) w_coin_reject = 1'b1;
          else                       w_total       = r_total + 4'd1;
        end
      end
      S_CHECK: begin
        w_coin_reject = coin_valid;
        if (r_total >= w_price) begin
          w_change_reg = r_total - w_price;
          w_timer      = BREW_LOAD;
          w_dispensing = 1'b1;
          w_state      = S_BREW;
        end else begin
          w_select_error = 1'b1;
          w_state        = S_COLLECT;
        end
      end
      S_BREW: begin
        w_coin_reject = coin_valid;
        w_timer       = r_timer - 8'd1;
        // Payout is registered on the edge the timer expires, so dispensing spans exactly BREW_CYCLES.
        if (r_timer <= 8'd1) begin
          w_change       = r_change_reg;
          w_change_valid = 1'b1;
          w_total        = 4'd0;
          w_state        = S_PAYOUT;
        end else begin
          w_dispensing = 1'b1;
        end
      end
      S_PAYOUT: begin
        w_coin_reject = coin_valid;
        w_state       = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_total        <= 4'd0;
      r_type         <= 2'd0;
      r_change_reg   <= 4'd0;
      r_timer        <= 8'd0;
      r_dispensing   <= 1'b0;
      r_change_valid <= 1'b0;
      r_change       <= 4'd0;
      r_coin_reject  <= 1'b0;
      r_select_error <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_state        <= w_state;
      r_total        <= w_total;
      r_type         <= w_type;
      r_change_reg   <= w_change_reg;
      r_timer        <= w_timer;
      r_dispensing   <= w_dispensing;
      r_change_valid <= w_change_valid;
      r_change       <= w_change;
      r_coin_reject  <= w_coin_reject;
      r_select_error <= w_select_error;
    end
  end

  assign state        = r_state;
  assign total_coins  = r_total;
  assign dispensing   = r_dispensing;
  assign change_valid = r_change_valid;
  assign change       = r_change;
  assign coin_reject  = r_coin_reject;
  assign select_error = r_select_error;

endmodule

// File: tb/tb_coffee_order_controller.sv
// Self-checking bench for coffee_order_controller: an order-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_coffee_order_controller;

  localparam int BREW = 8;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic       select_valid;
  logic [2:0] coffee_type;
  logic       cancel;
  logic [3:0] total_coins;
  logic       dispensing;
  logic       change_valid;
  logic [3:0] change;
  logic       coin_reject;
  logic       select_error;
  logic [2:0] state;

  coffee_order_controller dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .select_valid (select_valid),
    .coffee_type  (coffee_type),
    .cancel       (cancel),
    .total_coins  (total_coins),
    .dispensing   (dispensing),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject),
    .select_error (select_error),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_disp   = 0;
  int n_cv     = 0;
  int n_cr     = 0;
  bit m_live   = 1'b0;

  // Order-level model: credit, chosen drink (-1 none), brew cycles left, payout flag.
  int m_credit;
  int m_drink;
  int m_left;
  int m_owed;
  bit m_paying;
  bit m_cr;
  bit m_se;

  function automatic int price_of(input int d);
    case (d)
      0:       return 3;
      1:       return 4;
      2:       return 5;
      default: return 7;
    endcase
  endfunction

  // Observable state is derived from what the order is doing, not stored.
  function automatic int phase_of(input bit paying, input int left, input int drink, input int credit);
    if (paying)          return 4;
    else if (left > 0)   return 3;
    else if (drink >= 0) return 2;
    else if (credit > 0) return 1;
    else                 return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_credit <= 0;
      m_drink  <= -1;
      m_left   <= 0;
      m_owed   <= 0;
      m_paying <= 1'b0;
      m_cr     <= 1'b0;
      m_se     <= 1'b0;
    end else begin
      m_cr <= 1'b0;
      m_se <= 1'b0;
      case (phase_of(m_paying, m_left, m_drink, m_credit))
        4: begin
          m_paying <= 1'b0;
          m_cr     <= coin_valid;
        end
        3: begin
          m_cr   <= coin_valid;
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_paying <= 1'b1;
            m_owed   <= m_credit - price_of(m_drink);
            m_credit <= 0;
            m_drink  <= -1;
          end
        end
        2: begin
          m_cr <= coin_valid;
          if (m_credit >= price_of(m_drink)) m_left <= BREW;
          else begin
            m_se    <= 1'b1;
            m_drink <= -1;
          end
        end
        default: begin
          if (cancel && m_credit > 0) begin
            m_paying <= 1'b1;
            m_owed   <= m_credit;
            m_credit <= 0;
            m_cr     <= coin_valid;
          end else if (select_valid) begin
            m_cr <= coin_valid;
            if (m_credit > 0 && coffee_type < 3'd4) m_drink <= int'(coffee_type);
            else m_se <= 1'b1;
          end else if (coin_valid) begin
            if (m_credit == 15) m_cr <= 1'b1;
            else m_credit <= m_credit + 1;
          end
        end
      endcase
    end
  end

  logic [14:0] got_v;
  logic [14:0] exp_v;
  assign got_v = {state, total_coins, dispensing, change_valid, change, coin_reject, select_error};
  assign exp_v = {3'(phase_of(m_paying, m_left, m_drink, m_credit)), 4'(m_credit), (m_left > 0),
                  m_paying, 4'(m_owed), m_cr, m_se};

  always @(negedge clk) begin
    if (!rst && m_live) begin
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL model_compare t=%0t got={st,tot,disp,cv,chg,cr,se}=%h expected=%h", $time, got_v, exp_v);
      end
      n_disp += int'(dispensing);
      n_cv   += int'(change_valid);
      n_cr   += int'(coin_reject);
    end
  end

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic [2:0] t, input logic k);
    @(negedge clk);
    #1;
    coin_valid   = c;
    select_valid = s;
    coffee_type  = t;
    cancel       = k;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic coins(input int n);
    repeat (n) drive(1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  // which: 0 = change_valid, 1 = select_error, 2 = dispensing
  task automatic wait_for(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      idle();
      if ((which == 0 && change_valid) || (which == 1 && select_error) ||
          (which == 2 && dispensing)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0;
    int c0;
    int v0;
    rst = 1'b0;
    coin_valid = 1'b0; select_valid = 1'b0; coffee_type = 3'd0; cancel = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_total", int'(total_coins), 0);
    check("reset_disp", int'(dispensing), 0);
    check("reset_change", int'(change), 0);
    rst = 1'b0;
    m_live = 1'b1;

    // 5 coins, espresso: 8 brew cycles, change 2
    idle();
    d0 = n_disp;
    coins(5);
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    wait_for(0, 30, ok);
    check("t2_cv_seen", int'(ok), 1);
    check("t2_change", int'(change), 2);
    check("t2_total_payout", int'(total_coins), 0);
    check("t2_brew_cycles", n_disp - d0, BREW);
    idle();
    check("t2_state_idle", int'(state), 0);

    // 7 coins mocaccino: exact credit, change 0; then 6 coins is short
    coins(7);
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    wait_for(0, 30, ok);
    check("t3_cv_seen", int'(ok), 1);
    check("t3_change_zero", int'(change), 0);
    idle();
    coins(6);
    drive(1'b0, 1'b1, 3'd3, 1'b0);
    wait_for(1, 5, ok);
    check("t3_short_err", int'(ok), 1);
    check("t3_state_collect", int'(state), 1);
    check("t3_total_kept", int'(total_coins), 6);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    wait_for(0, 5, ok);
    check("t3_refund_seen", int'(ok), 1);
    check("t3_refund", int'(change), 6);

    // 16 coins saturate at 15, then milk coffee leaves 11
    idle();
    c0 = n_cr;
    coins(16);
    idle();
    check("t4_total_sat", int'(total_coins), 15);
    check("t4_one_reject", n_cr - c0, 1);
    drive(1'b0, 1'b1, 3'd1, 1'b0);
    wait_for(0, 30, ok);
    check("t4_cv_seen", int'(ok), 1);
    check("t4_change", int'(change), 11);

    // cancel beats select and coin in the same cycle
    idle();
    coins(3);
    c0 = n_cr;
    d0 = n_disp;
    drive(1'b1, 1'b1, 3'd0, 1'b1);
    wait_for(0, 5, ok);
    check("t5_cv_seen", int'(ok), 1);
    check("t5_refund", int'(change), 3);
    check("t5_coin_reject", n_cr - c0, 1);
    check("t5_no_brew", n_disp - d0, 0);

    // illegal code, then coins during brew are refused
    idle();
    coins(4);
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    wait_for(1, 3, ok);
    check("t6_illegal_err", int'(ok), 1);
    check("t6_state_collect", int'(state), 1);
    check("t6_total_kept", int'(total_coins), 4);
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    wait_for(2, 5, ok);
    check("t6_brew_start", int'(ok), 1);
    c0 = n_cr;
    coins(3);
    idle();
    check("t6_brew_rejects", n_cr - c0, 3);
    check("t6_total_brew", int'(total_coins), 4);
    check("t6_still_brew", int'(dispensing), 1);
    wait_for(0, 20, ok);
    check("t6_cv_seen", int'(ok), 1);
    check("t6_change", int'(change), 1);

    // reset on the 3rd brew cycle of a cappuccino
    idle();
    coins(6);
    drive(1'b0, 1'b1, 3'd2, 1'b0);
    wait_for(2, 5, ok);
    check("t1_brew_start", int'(ok), 1);
    idle();
    idle();
    rst = 1'b1;
    #1;
    check("t1_rst_disp", int'(dispensing), 0);
    check("t1_rst_total", int'(total_coins), 0);
    check("t1_rst_state", int'(state), 0);
    check("t1_rst_change", int'(change), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    v0 = n_cv;
    repeat (15) idle();
    check("t1_no_payout", n_cv - v0, 0);
    check("t1_state_idle", int'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
